// File: rtl/slowclk_tick_rx_if.sv
// Slow-clock receiver bundle: raw slow clock in; ticks, period measurement and status out.
// master is the receiver side, slave is the consumer that sources clk_slow and reads results.
interface slowclk_tick_rx_if #(
  parameter int CNT_W = 27
);
  logic             clk_slow;
  logic             tick_rise;
  logic             tick_fall;
  logic [CNT_W-1:0] period;
  logic             period_valid;
  logic             stalled;
  logic [15:0]      edge_count;

  modport master (
    input  clk_slow,
    output tick_rise, tick_fall, period, period_valid, stalled, edge_count
  );

  modport slave (
    output clk_slow,
    input  tick_rise, tick_fall, period, period_valid, stalled, edge_count
  );
endinterface

// File: rtl/slowclk_tick_rx.sv
// Brings an asynchronous slow clock into clk_100MHz as rise/fall enable ticks, measures its period and flags a stall.
// Optional macro GLITCH_FILTER_EN: the synchronized level must hold FILTER_LEN cycles before it is accepted.
module slowclk_tick_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W       = 27,
  parameter int TIMEOUT     = 12_000_000,
  parameter int FILTER_LEN  = 4
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  slowclk_tick_rx_if.master bus
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (FILTER_LEN < 1) begin : g_bad_filter
    $error("FILTER_LEN must be at least 1");
  end

  typedef enum logic [1:0] {WAIT_FIRST, MEASURE, STALLED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT - 1);
`ifdef GLITCH_FILTER_EN
  localparam int WARM = SYNC_STAGES + 2;
`else
  localparam int WARM = SYNC_STAGES + 1;
`endif
  localparam int WARM_W = $clog2(WARM + 1);

  state_t                 state, state_nxt;
  logic [SYNC_STAGES-1:0] sync_p;
  logic                   sync_lvl;
  logic                   lvl;
  logic                   prev;
  logic [WARM_W-1:0]      warm;
  logic                   armed;
  logic                   rise, fall;
  logic [CNT_W-1:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0]       period_r, period_nxt;
  logic                   vld_r, vld_nxt;
  logic                   tick_rise_r, tick_fall_r;
  logic [15:0]            edge_cnt;

  // stage 0: synchronizer chain
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) sync_p <= '0;
    else       sync_p <= {sync_p[SYNC_STAGES-2:0], bus.clk_slow};
  end
  assign sync_lvl = sync_p[SYNC_STAGES-1];

  // Edges are masked until the chain and prev hold real samples, so a level
  // already high at reset release is not mistaken for a rising edge.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset)       warm <= '0;
    else if (!armed) warm <= warm + WARM_W'(1);
  end
  assign armed = (warm == WARM_W'(WARM));

  // stage 1: optional glitch filter producing the accepted level
`ifdef GLITCH_FILTER_EN
  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  logic [FLT_W-1:0] flt_cnt;

  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      lvl     <= 1'b0;
      flt_cnt <= '0;
    end else if (!armed) begin
      lvl     <= sync_lvl;
      flt_cnt <= '0;
    end else if (sync_lvl == lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      lvl     <= sync_lvl;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end
`else
  assign lvl = sync_lvl;
`endif

  // stage 2: edge detect
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) prev <= 1'b0;
    else       prev <= lvl;
  end
  assign rise = armed &  lvl & ~prev;
  assign fall = armed & ~lvl &  prev;

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
    period_nxt = period_r;
    vld_nxt    = vld_r;
    if (rise) begin
      cnt_nxt   = '0;
      state_nxt = MEASURE;
      if (state == MEASURE) begin
        period_nxt = cnt + CNT_W'(1);
        vld_nxt    = 1'b1;
      end
    end else if (state != STALLED && cnt == TMO_LAST) begin
      state_nxt = STALLED;
      vld_nxt   = 1'b0;
    end
  end

  // stage 3: registered ticks, measurement and status
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state       <= WAIT_FIRST;
      cnt         <= '0;
      period_r    <= '0;
      vld_r       <= 1'b0;
      tick_rise_r <= 1'b0;
      tick_fall_r <= 1'b0;
      edge_cnt    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      period_r    <= period_nxt;
      vld_r       <= vld_nxt;
      tick_rise_r <= rise;
      tick_fall_r <= fall;
      if (rise) edge_cnt <= edge_cnt + 16'd1;
    end
  end

  assign bus.tick_rise    = tick_rise_r;
  assign bus.tick_fall    = tick_fall_r;
  assign bus.period       = period_r;
  assign bus.period_valid = vld_r;
  assign bus.stalled      = (state == STALLED);
  assign bus.edge_count   = edge_cnt;

endmodule
